mem_arbiter: RTL

- Shares the single-port 128-word instruction/data RAM between the instruction-fetch path and the load/store path.
- Arbitrates round-robin, sequences the RAM chip-select and write-enable, and latches the request for the access.
- Returns read data and a one-cycle ack to the granted requester.
- Sits between the fetch/LSU logic and the memory block; the RAM tri-state bus is resolved outside this block into mem_wdata/mem_rdata.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester (fetch/LSU) and RAM-side signals around the memory arbiter.
// The arbiter uses the slave view; the surrounding fetch/LSU/RAM logic uses the master view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_err;

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
    output mem_cs, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
    input  mem_cs, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch and load/store.
// Each transaction is IDLE (grant/latch) -> ACCESS (RAM cycle) -> DONE (ack), all outputs registered.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 128
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
  typedef enum logic {PortI = 1'b0, PortD = 1'b1} port_e;

  state_e            state_q, state_d;
  port_e             last_grant_q, last_grant_d;
  port_e             owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              i_err_q, i_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic              any_req;
  port_e             gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              sel_in_range;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    any_req = bus.i_req | bus.d_req;
    if (bus.i_req && bus.d_req) begin
      gnt = (last_grant_q == PortD) ? PortI : PortD;
    end else if (bus.d_req) begin
      gnt = PortD;
    end else begin
      gnt = PortI;
    end
    sel_addr     = (gnt == PortD) ? bus.d_addr : bus.i_addr;
    sel_we       = (gnt == PortD) & bus.d_we;
    sel_in_range = sel_addr < ADDR_W'(MEM_DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= PortD;
      owner_q      <= PortI;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ack_q      <= i_ack_d;
      i_err_q      <= i_err_d;
      i_rdata_q    <= i_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d      = gnt;
          last_grant_d = gnt;
          addr_d       = sel_addr;
          we_d         = sel_we;
          wdata_d      = bus.d_wdata;
          err_d        = ~sel_in_range;
          state_d      = sel_in_range ? StAccess : StDone;
        end
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are computed for the state being entered so that they are registered.
  always_comb begin
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    i_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    busy_d      = (state_d != StIdle);

    if (state_d == StAccess) begin
      mem_cs_d    = 1'b1;
      mem_we_d    = we_d;
      mem_addr_d  = addr_d;
      mem_wdata_d = we_d ? wdata_d : '0;
    end

    // RAM output settled on the negedge inside ACCESS; loads only.
    if (state_q == StAccess && !we_q) begin
      if (owner_q == PortD) begin
        d_rdata_d = bus.mem_rdata;
      end else begin
        i_rdata_d = bus.mem_rdata;
      end
    end

    if (state_d == StDone) begin
      if (owner_d == PortD) begin
        d_ack_d = 1'b1;
        d_err_d = err_d;
        if (err_d) d_rdata_d = '0;
      end else begin
        i_ack_d = 1'b1;
        i_err_d = err_d;
        if (err_d) i_rdata_d = '0;
      end
    end
  end

  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_err     = i_err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;

endmodule
